// File: rtl/draw_cursor_if.sv
// vga_if: one pixel of VGA raster timing plus its colour.
//   hcount, vcount : pixel column / row counters (12 bit)
//   hsync, vsync   : sync pulses
//   hblnk, vblnk   : horizontal / vertical blanking
//   rgb            : RGB444 colour
// Modport "in" is the consumer view, "out" the producer view.
interface vga_if;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_cursor.sv
// draw_cursor: overlays a selectable, optionally blinking 2-bit bitmap cursor
// on a VGA pixel stream with a fixed 3-cycle latency on every field.
//   clk         : pixel clock
//   rst         : asynchronous active-low reset
//   vga_in      : incoming timing + background colour
//   vga_out     : timing delayed 3 cycles + composited colour
//   xpos, ypos  : top-left of the cursor bitmap
//   shape_sel   : bitmap select (out-of-range values select shape 0)
//   blink_en    : enable blinking
//   cursor_en   : global cursor enable
//   frame_start : one-cycle pulse after position/shape are latched
module draw_cursor #(
   parameter int unsigned CUR_W        = 16,
   parameter int unsigned CUR_H        = 16,
   parameter int unsigned NUM_SHAPES   = 4,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter logic [11:0] COLOR_FG     = 12'hFFF,
   parameter logic [11:0] COLOR_OL     = 12'h000,
   localparam int unsigned SW = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1
) (
   input  logic          clk,
   input  logic          rst,
   vga_if.in             vga_in,
   vga_if.out            vga_out,
   input  logic [11:0]   xpos,
   input  logic [11:0]   ypos,
   input  logic [SW-1:0] shape_sel,
   input  logic          blink_en,
   input  logic          cursor_en,
   output logic          frame_start
);

   localparam int unsigned XW = $clog2(CUR_W);
   localparam int unsigned YW = $clog2(CUR_H);
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [1:0] CODE_CLEAR   = 2'd0;
   localparam logic [1:0] CODE_FILL    = 2'd1;
   localparam logic [1:0] CODE_OUTLINE = 2'd2;
   localparam logic [1:0] CODE_INVERT  = 2'd3;

   typedef struct packed {
      logic [11:0] hcount;
      logic [11:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } pix_t;

   // Cursor bitmap ROM, addressed by (shape, column, row).
   //   shape 0 : arrow (outlined triangle, one inverting row)
   //   shape 1 : inverting crosshair
   //   shape 2 : outlined filled box
   //   shape 3+: diagonal stripes of all four codes
   function automatic logic [1:0] rom_code(input logic [SW-1:0] shape,
                                           input logic [XW-1:0] x,
                                           input logic [YW-1:0] y);
      logic [3:0] s;
      logic [6:0] xi;
      logic [6:0] yi;
      logic [1:0] code;
      s    = 4'(shape);
      xi   = 7'(x);
      yi   = 7'(y);
      code = CODE_CLEAR;
      if (s == 4'd0) begin
         if (xi > yi)
            code = CODE_CLEAR;
         else if (xi == 7'd0 || xi == yi || yi == 7'(CUR_H - 1))
            code = CODE_OUTLINE;
         else if (yi == 7'(CUR_H / 2))
            code = CODE_INVERT;
         else
            code = CODE_FILL;
      end else if (s == 4'd1) begin
         if (xi == 7'(CUR_W / 2) || yi == 7'(CUR_H / 2))
            code = CODE_INVERT;
      end else if (s == 4'd2) begin
         if (xi == 7'd0 || yi == 7'd0 || xi == 7'(CUR_W - 1) || yi == 7'(CUR_H - 1))
            code = CODE_OUTLINE;
         else
            code = CODE_FILL;
      end else begin
         code = 2'(xi + yi + 7'(s));
      end
      return code;
   endfunction

   // Shadow (per-frame) state
   logic [11:0]   xs;
   logic [11:0]   ys;
   logic [SW-1:0] shape_s;
   logic          en_s;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   // Pipeline state
   pix_t          s1_pix;
   logic          s1_act;
   logic [XW-1:0] s1_dx;
   logic [YW-1:0] s1_dy;
   logic [SW-1:0] s1_shape;
   pix_t          s2_pix;
   logic          s2_act;
   logic [1:0]    s2_code;
   pix_t          s3_pix;

   // Combinational helpers
   logic          fs_c;
   logic [SW-1:0] shape_in_c;
   logic [11:0]   xs_c;
   logic [11:0]   ys_c;
   logic [SW-1:0] shape_c;
   logic          en_c;
   logic          phase_c;
   logic [BW-1:0] blink_cnt_nxt_c;
   logic          blink_phase_nxt_c;
   logic          hit_c;
   pix_t          in_c;
   logic [11:0]   rgb_c;
   pix_t          s3_nxt_c;

   assign fs_c = (vga_in.hcount == 12'd0) && (vga_in.vcount == 12'd0);

   assign in_c = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                   hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                   hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                   rgb:    vga_in.rgb};

   // Out-of-range shape selects fall back to shape 0
   generate
      if (NUM_SHAPES == (1 << SW)) begin : g_shape_full
         assign shape_in_c = shape_sel;
      end else begin : g_shape_clamp
         assign shape_in_c = ({1'b0, shape_sel} >= (SW + 1)'(NUM_SHAPES)) ? '0 : shape_sel;
      end
   endgenerate

   // Blink state that would be committed at this frame start
   always_comb begin
      blink_cnt_nxt_c   = blink_cnt;
      blink_phase_nxt_c = blink_phase;
      if (!blink_en) begin
         blink_cnt_nxt_c   = '0;
         blink_phase_nxt_c = 1'b1;
      end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
         blink_cnt_nxt_c   = '0;
         blink_phase_nxt_c = ~blink_phase;
      end else begin
         blink_cnt_nxt_c   = blink_cnt + BW'(1);
      end
   end

   // Pixel (0,0) is tested against the values being latched on this very cycle
   assign xs_c    = fs_c ? xpos              : xs;
   assign ys_c    = fs_c ? ypos              : ys;
   assign shape_c = fs_c ? shape_in_c        : shape_s;
   assign en_c    = fs_c ? cursor_en         : en_s;
   assign phase_c = fs_c ? blink_phase_nxt_c : blink_phase;

   // 13-bit compare so the box end never wraps back to column/row 0
   assign hit_c = ({1'b0, vga_in.hcount} >= {1'b0, xs_c})
               && ({1'b0, vga_in.hcount} <  ({1'b0, xs_c} + 13'(CUR_W)))
               && ({1'b0, vga_in.vcount} >= {1'b0, ys_c})
               && ({1'b0, vga_in.vcount} <  ({1'b0, ys_c} + 13'(CUR_H)));

   // Shadow registers, blink state and frame_start pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xs          <= '0;
         ys          <= '0;
         shape_s     <= '0;
         en_s        <= 1'b0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= fs_c;
         if (fs_c) begin
            xs          <= xpos;
            ys          <= ypos;
            shape_s     <= shape_in_c;
            en_s        <= cursor_en;
            blink_cnt   <= blink_cnt_nxt_c;
            blink_phase <= blink_phase_nxt_c;
         end
      end
   end

   // S3 compositing; blanking comes from the delayed timing of the same pixel
   always_comb begin
      rgb_c = s2_pix.rgb;
      if (s2_pix.hblnk || s2_pix.vblnk) begin
         rgb_c = '0;
      end else if (s2_act) begin
         case (s2_code)
            CODE_FILL:    rgb_c = COLOR_FG;
            CODE_OUTLINE: rgb_c = COLOR_OL;
            CODE_INVERT:  rgb_c = ~s2_pix.rgb;
            default:      rgb_c = s2_pix.rgb;
         endcase
      end
      s3_nxt_c     = s2_pix;
      s3_nxt_c.rgb = rgb_c;
   end

   // S1 hit/offset, S2 ROM read, S3 output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_pix   <= '0;
         s1_act   <= 1'b0;
         s1_dx    <= '0;
         s1_dy    <= '0;
         s1_shape <= '0;
         s2_pix   <= '0;
         s2_act   <= 1'b0;
         s2_code  <= '0;
         s3_pix   <= '0;
      end else begin
         s1_pix   <= in_c;
         s1_act   <= hit_c && en_c && phase_c;
         s1_dx    <= XW'(vga_in.hcount - xs_c);
         s1_dy    <= YW'(vga_in.vcount - ys_c);
         s1_shape <= shape_c;
         s2_pix   <= s1_pix;
         s2_act   <= s1_act;
         s2_code  <= rom_code(s1_shape, s1_dx, s1_dy);
         s3_pix   <= s3_nxt_c;
      end
   end

   assign vga_out.hcount = s3_pix.hcount;
   assign vga_out.vcount = s3_pix.vcount;
   assign vga_out.hsync  = s3_pix.hsync;
   assign vga_out.vsync  = s3_pix.vsync;
   assign vga_out.hblnk  = s3_pix.hblnk;
   assign vga_out.vblnk  = s3_pix.vblnk;
   assign vga_out.rgb    = s3_pix.rgb;

endmodule

// File: doc/draw_cursor.md
DRAW_CURSOR -- requirements
Module: draw_cursor

Interface
REQ-001 SHALL have parameter CUR_W, default 16, meaning cursor bitmap width in pixels (power of two, 4..64).
REQ-002 SHALL have parameter CUR_H, default 16, meaning cursor bitmap height in pixels (4..64).
REQ-003 SHALL have parameter NUM_SHAPES, default 4, meaning number of selectable bitmaps (1..8).
REQ-004 SHALL have parameter BLINK_FRAMES, default 30, meaning frames per blink half-period (>=1).
REQ-005 SHALL have parameter COLOR_FG, default 12'hFFF, meaning fill colour (RGB444).
REQ-006 SHALL have parameter COLOR_OL, default 12'h000, meaning outline colour.
REQ-007 SHALL have port clk, in, 1, pixel clock; all logic on its rising edge.
REQ-008 SHALL have port rst, in, 1, asynchronous active-low reset.
REQ-009 SHALL have port vga_in, vga_if.in, -, timing and background (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb).
REQ-010 SHALL have port vga_out, vga_if.out, -, delayed timing plus composited rgb.
REQ-011 SHALL have port xpos, in, 12, cursor hotspot column (top-left of bitmap).
REQ-012 SHALL have port ypos, in, 12, cursor hotspot row.
REQ-013 SHALL have port shape_sel, in, clog2(NUM_SHAPES) (min 1), bitmap select.
REQ-014 SHALL have port blink_en, in, 1, enable cursor blinking.
REQ-015 SHALL have port cursor_en, in, 1, global cursor enable.
REQ-016 SHALL have port frame_start, out, 1, one-cycle pulse when position/shape latched.

Function
REQ-017 SHALL hold an internal ROM of NUM_SHAPES x CUR_H x CUR_W 2-bit codes: 0 transparent, 1 fill, 2 outline, 3 invert.
REQ-018 SHALL latch xpos, ypos, shape_sel, cursor_en into shadow registers only on the cycle vga_in.hcount==0 && vga_in.vcount==0; frame_start pulses high the following cycle.
REQ-019 SHALL never change shadow values mid-frame; input changes mid-frame take effect at next frame start.
REQ-020 SHALL use shape_sel values >= NUM_SHAPES as shape 0.
REQ-021 SHALL have a 3-stage pipeline: S1 hit test and offset (dx=hcount-xs, dy=vcount-ys, 12-bit unsigned), S2 registered ROM read, S3 registered compositing.
REQ-022 SHALL have a fixed latency of exactly 3 cycles from vga_in to vga_out for every field (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb).
REQ-023 SHALL assert hit iff hcount>=xs && hcount<xs+CUR_W && vcount>=ys && vcount<ys+CUR_H, computed at 13 bits so xs+CUR_W never wraps.
REQ-024 SHALL have cursor partially off-screen (xs or ys near 4095) clip silently; there is no wrap to column/row 0.
REQ-025 SHALL have a blink counter that increments once per frame_start while blink_en=1; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
REQ-026 SHALL, when blink_en=0, clear the counter, force blink_phase=1 (visible) on the next frame_start, and keep it there.
REQ-027 SHALL set visible = hit && shadow cursor_en && blink_phase && !(hblnk||vblnk), all aligned to the same pixel.
REQ-028 SHALL set rgb_out: blank -> 12'h000; !visible or code 0 -> rgb_in; code 1 -> COLOR_FG; code 2 -> COLOR_OL; code 3 -> ~rgb_in.
REQ-029 SHALL take blanking from the delayed hblnk/vblnk of the same pixel, never the current input.
REQ-030 SHALL, when frame start coincides with a hit pixel at (0,0), use the newly latched values for that pixel.

Reset
REQ-031 SHALL, while rst=0, asynchronously clear all pipeline registers, vga_out fields, and frame_start to 0.
REQ-032 SHALL set reset values: shadow xs=ys=0, shape=0, cursor_en=0, blink counter 0, blink_phase=1.
REQ-033 SHALL, on reset deassertion mid-frame, output rgb_in passthrough (cursor disabled) until the first frame start.

Verification
REQ-034 SHALL cover 640x480 frame, xpos=100, ypos=50, shape 0, cursor_en=1 -> bitmap pixels at (100..115, 50..65) only, vga_out equal to vga_in delayed 3 cycles elsewhere.
REQ-035 SHALL cover xpos changed to 200 at vcount=240 -> remainder of frame drawn at 100; next frame at 200; frame_start one pulse per frame.
REQ-036 SHALL cover xpos=630, ypos=470 -> only columns 630..639 and rows 470..479 drawn; nothing at column 0 or row 0.
REQ-037 SHALL cover blink_en=1, BLINK_FRAMES=2 -> cursor visible 2 frames, hidden 2, visible 2; blink_en=0 -> visible from next frame.
REQ-038 SHALL cover code 3 pixel over rgb_in=12'h0F0 -> 12'hF0F; blanked pixel inside cursor box -> 12'h000.
REQ-039 SHALL cover rst asserted mid-line -> all outputs 0 immediately; after release, cursor absent until vcount=hcount=0 seen.
